// File: rtl/bbc_ram_pkg.sv
// Shared types and sizes for the main-RAM slot scheduler.
package bbc_ram_pkg;
  localparam int RAM_ADDR_W = 15;
  localparam int RAM_DATA_W = 8;

  typedef enum logic [1:0] {
    SL_VID_A = 2'd0,
    SL_CPU   = 2'd1,
    SL_VID_B = 2'd2,
    SL_SPARE = 2'd3
  } slot_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_VID  = 2'd1,
    OWN_CPU  = 2'd2,
    OWN_AUX  = 2'd3
  } owner_t;
endpackage

// File: rtl/ram_slot_sequencer.sv
// Four-slot rotation and per-tick owner pick; aux only fills slots its fixed owner leaves unused.
module ram_slot_sequencer
  import bbc_ram_pkg::*;
(
  input  logic       clk,
  input  logic       RESET,
  input  logic       clk_en,
  input  logic       vid_req,
  input  logic       cpu_sel,
  input  logic       aux_req,
  output logic [1:0] slot,
  output logic [1:0] owner
);
  slot_t  st, st_nxt;
  owner_t own;

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) st <= SL_VID_A;
    else       st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    if (clk_en) begin
      case (st)
        SL_VID_A: st_nxt = SL_CPU;
        SL_CPU:   st_nxt = SL_VID_B;
        SL_VID_B: st_nxt = SL_SPARE;
        default:  st_nxt = SL_VID_A;
      endcase
    end
  end

  always_comb begin
    own = OWN_NONE;
    if (clk_en) begin
      case (st)
        SL_VID_A, SL_VID_B: own = vid_req ? OWN_VID : (aux_req ? OWN_AUX : OWN_NONE);
        SL_CPU:             own = cpu_sel ? OWN_CPU : (aux_req ? OWN_AUX : OWN_NONE);
        default:            own = aux_req ? OWN_AUX : OWN_NONE;
      endcase
    end
  end

  assign slot  = st;
  assign owner = own;
endmodule

// File: rtl/ram_scheduler.sv
// Time-slot arbiter for the shared main RAM: address mux, one-entry read-return tag, output regs.
module ram_scheduler
  import bbc_ram_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic              clk_en,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_data,
  output logic              vid_valid,
  input  logic              cpu_sel,
  input  logic              cpu_rnw,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_done,
  input  logic              aux_req,
  input  logic              aux_we,
  input  logic [ADDR_W-1:0] aux_addr,
  input  logic [DATA_W-1:0] aux_wdata,
  output logic [DATA_W-1:0] aux_rdata,
  output logic              aux_done,
  output logic [1:0]        slot,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);
  logic [1:0]        seq_owner;
  owner_t            own, rd_tag, rd_own, wr_own;
  logic [ADDR_W-1:0] addr_q, sel_addr;
  logic [DATA_W-1:0] wdata_q, sel_wdata;
  logic              sel_we;

  ram_slot_sequencer u_seq (
    .clk     (clk),
    .RESET   (RESET),
    .clk_en  (clk_en),
    .vid_req (vid_req),
    .cpu_sel (cpu_sel),
    .aux_req (aux_req),
    .slot    (slot),
    .owner   (seq_owner)
  );

  // A tick coinciding with reset is discarded so no write lands in the RAM.
  assign own = RESET ? OWN_NONE : owner_t'(seq_owner);

  always_comb begin
    sel_addr  = addr_q;
    sel_wdata = wdata_q;
    sel_we    = 1'b0;
    case (own)
      OWN_VID: sel_addr = vid_addr;
      OWN_CPU: begin
        sel_addr  = cpu_addr;
        sel_wdata = cpu_wdata;
        sel_we    = ~cpu_rnw;
      end
      OWN_AUX: begin
        sel_addr  = aux_addr;
        sel_wdata = aux_wdata;
        sel_we    = aux_we;
      end
      default: ;
    endcase
  end

  assign rd_own    = (own != OWN_NONE && !sel_we) ? own : OWN_NONE;
  assign wr_own    = sel_we ? own : OWN_NONE;
  assign ram_addr  = sel_addr;
  assign ram_wdata = sel_wdata;
  assign ram_we    = sel_we;

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_tag    <= OWN_NONE;
      vid_data  <= '0;
      cpu_rdata <= '0;
      aux_rdata <= '0;
      vid_valid <= 1'b0;
      cpu_done  <= 1'b0;
      aux_done  <= 1'b0;
    end else begin
      if (own != OWN_NONE) begin
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
      end
      // Tag lives exactly one clk: the cycle ram_rdata is valid.
      rd_tag    <= rd_own;
      vid_valid <= (rd_tag == OWN_VID);
      cpu_done  <= (rd_tag == OWN_CPU) || (wr_own == OWN_CPU);
      aux_done  <= (rd_tag == OWN_AUX) || (wr_own == OWN_AUX);
      if (rd_tag == OWN_VID) vid_data  <= ram_rdata;
      if (rd_tag == OWN_CPU) cpu_rdata <= ram_rdata;
      if (rd_tag == OWN_AUX) aux_rdata <= ram_rdata;
    end
  end
endmodule

// File: tb/tb_ram_scheduler.sv
// Directed bench for ram_scheduler with an external RAM and a slot-level behavioural model.
module tb_ram_scheduler;
  logic        clk = 0, RESET = 1, clk_en = 0;
  logic        vid_req = 0, cpu_sel = 0, cpu_rnw = 1, aux_req = 0, aux_we = 0;
  logic [14:0] vid_addr = 0, cpu_addr = 0, aux_addr = 0;
  logic [7:0]  cpu_wdata = 0, aux_wdata = 0;
  logic [7:0]  vid_data, cpu_rdata, aux_rdata, ram_wdata, ram_rdata;
  logic        vid_valid, cpu_done, aux_done, ram_we;
  logic [1:0]  slot;
  logic [14:0] ram_addr;

  ram_scheduler dut (
    .clk(clk), .RESET(RESET), .clk_en(clk_en),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data), .vid_valid(vid_valid),
    .cpu_sel(cpu_sel), .cpu_rnw(cpu_rnw), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_done(cpu_done),
    .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
    .aux_rdata(aux_rdata), .aux_done(aux_done),
    .slot(slot), .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // External synchronous RAM
  logic [7:0] ram [0:32767];
  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_wdata;
    ram_rdata <= ram[ram_addr];
  end

  function automatic logic [7:0] pat(input int a);
    return 8'(((a & 255) + ((a >> 8) & 127) * 3 + 1) & 255);
  endfunction

  int n_vec = 0, n_err = 0, cyc = 0, cpu_done_cnt = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (cpu_done) cpu_done_cnt <= cpu_done_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, exp);
    end
  endtask

  // Behavioural model: slot counter, model memory, one pending completion event
  logic [7:0]  mmem [0:32767];
  int          m_slot = 0, pend_cyc = -1, pend_who = 0;
  logic        pend_rd = 0;
  logic [7:0]  pend_data = 0, m_vd = 0, m_cd = 0, m_ad = 0;
  logic [14:0] m_addr = 0;

  always @(negedge clk) begin
    int who; logic e_vv, e_cd, e_ad, e_we; logic [14:0] e_addr; logic [7:0] e_wd;
    if (RESET) begin
      m_slot = 0; pend_who = 0; m_vd = 0; m_cd = 0; m_ad = 0; m_addr = 0;
      chk("rst_slot", slot, 0);
      chk("rst_we", ram_we, 0);
      chk("rst_addr", ram_addr, 0);
      chk("rst_pulses", {vid_valid, cpu_done, aux_done}, 0);
      chk("rst_data", {vid_data, cpu_rdata, aux_rdata}, 0);
    end else begin
      e_vv = 0; e_cd = 0; e_ad = 0;
      if (pend_who != 0 && pend_cyc == cyc) begin
        case (pend_who)
          1: begin e_vv = 1; if (pend_rd) m_vd = pend_data; end
          2: begin e_cd = 1; if (pend_rd) m_cd = pend_data; end
          default: begin e_ad = 1; if (pend_rd) m_ad = pend_data; end
        endcase
        pend_who = 0;
      end
      who = 0;
      if (clk_en) begin
        if (m_slot == 0 || m_slot == 2) who = vid_req ? 1 : (aux_req ? 3 : 0);
        else if (m_slot == 1)           who = cpu_sel ? 2 : (aux_req ? 3 : 0);
        else                            who = aux_req ? 3 : 0;
      end
      e_addr = m_addr; e_we = 0; e_wd = 0;
      case (who)
        1: e_addr = vid_addr;
        2: begin e_addr = cpu_addr; e_we = !cpu_rnw; e_wd = cpu_wdata; end
        3: begin e_addr = aux_addr; e_we = aux_we; e_wd = aux_wdata; end
        default: ;
      endcase
      chk("slot", slot, m_slot);
      chk("ram_we", ram_we, e_we);
      chk("ram_addr", ram_addr, e_addr);
      if (e_we) chk("ram_wdata", ram_wdata, e_wd);
      chk("vid_valid", vid_valid, e_vv);
      chk("cpu_done", cpu_done, e_cd);
      chk("aux_done", aux_done, e_ad);
      chk("vid_data", vid_data, m_vd);
      chk("cpu_rdata", cpu_rdata, m_cd);
      chk("aux_rdata", aux_rdata, m_ad);
      if (clk_en) begin
        if (who != 0) begin
          m_addr = e_addr;
          pend_who = who;
          pend_rd = !e_we;
          if (e_we) begin mmem[e_addr] = e_wd; pend_cyc = cyc + 1; end
          else begin pend_data = mmem[e_addr]; pend_cyc = cyc + 2; end
        end
        m_slot = (m_slot + 1) % 4;
      end
    end
  end

  // Strobe one clk wide, next strobe four clks later
  task automatic tick();
    clk_en = 1;
    @(posedge clk); #1 clk_en = 0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic skip_to(input int s);
    for (int i = 0; i < 4 && m_slot != s; i++) tick();
  endtask

  initial begin
    for (int a = 0; a < 32768; a++) begin ram[a] = pat(a); mmem[a] = pat(a); end
    ram[15'h3000] = 8'hA5; mmem[15'h3000] = 8'hA5;
    repeat (3) @(posedge clk);
    #1 RESET = 0;
    chk("lit_reset_slot", slot, 0);

    for (int i = 0; i < 8; i++) tick();
    chk("lit_idle_slot", slot, 0);

    // Video fetch in SL_VID_A; SL_CPU tick with vid_req held stays idle
    vid_req = 1; vid_addr = 15'h3000;
    tick();
    chk("lit_vid_data", vid_data, 8'hA5);
    tick();
    vid_req = 0;
    tick(); tick();

    // CPU write then read back in the next SL_CPU
    tick();
    cpu_sel = 1; cpu_rnw = 0; cpu_addr = 15'h0123; cpu_wdata = 8'h5A;
    tick();
    cpu_sel = 0;
    tick(); tick(); tick();
    cpu_sel = 1; cpu_rnw = 1;
    tick();
    cpu_sel = 0;
    chk("lit_cpu_rdata", cpu_rdata, 8'h5A);

    // Aux write with both fixed owners busy: only SL_SPARE is donated
    vid_req = 1; vid_addr = 15'h1000; cpu_sel = 1; cpu_rnw = 1; cpu_addr = 15'h0200;
    aux_req = 1; aux_we = 1; aux_addr = 15'h7FFF; aux_wdata = 8'h11;
    tick();
    chk("lit_vid_b_data", vid_data, 8'h31);
    chk("lit_aux_not_yet", ram[15'h7FFF], pat(15'h7FFF));
    tick();
    aux_req = 0;
    chk("lit_aux_wr", ram[15'h7FFF], 8'h11);
    // With cpu_sel low the SL_CPU tick goes to aux
    cpu_sel = 0; aux_req = 1; aux_addr = 15'h0000; aux_wdata = 8'h22;
    tick(); tick();
    aux_req = 0; vid_req = 0;
    chk("lit_aux_cpu_slot", ram[15'h0000], 8'h22);

    // Aux read in donated SL_VID_B, then CPU read: no cross-steering
    aux_req = 1; aux_we = 0; aux_addr = 15'h4444;
    tick();
    aux_req = 0;
    tick(); tick();
    cpu_sel = 1; cpu_rnw = 1; cpu_addr = 15'h0555;
    tick();
    cpu_sel = 0;
    chk("lit_aux_rdata", aux_rdata, 8'h11);
    chk("lit_cpu_rdata2", cpu_rdata, 8'h65);

    // Reset lands one clk after a CPU read tick: access dropped
    skip_to(1);
    cpu_done_cnt = 0;
    cpu_sel = 1; cpu_rnw = 1; cpu_addr = 15'h0123;
    clk_en = 1;
    @(posedge clk); #1 clk_en = 0; cpu_sel = 0; RESET = 1;
    repeat (2) @(posedge clk); #1 RESET = 0;
    repeat (3) @(posedge clk); #1;
    chk("lit_rst_no_done", cpu_done_cnt, 0);
    chk("lit_rst_rdata", cpu_rdata, 0);
    chk("lit_rst_slot", slot, 0);

    // A write tick coinciding with reset is not performed
    aux_req = 1; aux_we = 1; aux_addr = 15'h0100; aux_wdata = 8'h77;
    clk_en = 1; RESET = 1;
    @(posedge clk); #1 clk_en = 0; RESET = 0; aux_req = 0;
    repeat (2) @(posedge clk); #1;
    chk("lit_rst_no_write", ram[15'h0100], 8'h04);
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout at cycle %0d", cyc);
    $fatal(1);
  end
endmodule
